// File: rtl/adder_arbiter.sv
// Shares one 16-bit adder between two requesters over a req/ack handshake.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties) instead of round-robin.

module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        overflow
);
    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};
endmodule

module adder_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [1:0]  req,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic        cin0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    input  logic        cin1,
    output logic [1:0]  ack,
    output logic [1:0]  done,
    output logic        grant_id,
    output logic [15:0] sum,
    output logic        overflow,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    logic        opc_q, opc_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  done_q, done_d;
    logic        gid_q, gid_d;
    logic [15:0] sum_q, sum_d;
    logic        ovf_q, ovf_d;
    logic        busy_q, busy_d;
    logic        winner;
    logic [15:0] add_sum;
    logic        add_ovf;

`ifdef ADDER_ARB_FIXED_PRIO_EN
    assign winner = ~req[0];
`else
    logic ptr_q, ptr_d;
    // On a tie the requester that was not granted last wins.
    assign winner = (&req) ? ~ptr_q : ~req[0];
`endif

    // Adder sees only the operand registers, so its inputs are frozen through CALC.
    adder_16bit u_adder (
        .a        (opa_q),
        .b        (opb_q),
        .cin      (opc_q),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        opc_d   = opc_q;
        ack_d   = 2'b00;
        done_d  = 2'b00;
        gid_d   = gid_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
`ifndef ADDER_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    opa_d   = winner ? a1 : a0;
                    opb_d   = winner ? b1 : b0;
                    opc_d   = winner ? cin1 : cin0;
                    ack_d   = winner ? 2'b10 : 2'b01;
                    gid_d   = winner;
                    busy_d  = 1'b1;
                    cnt_d   = 4'(SETTLE_CYCLES - 1);
                    state_d = CALC;
`ifndef ADDER_ARB_FIXED_PRIO_EN
                    ptr_d   = winner;
`endif
                end
            end
            CALC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    sum_d   = add_sum;
                    ovf_d   = add_ovf;
                    done_d  = gid_q ? 2'b10 : 2'b01;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            opa_q   <= 16'd0;
            opb_q   <= 16'd0;
            opc_q   <= 1'b0;
            ack_q   <= 2'b00;
            done_q  <= 2'b00;
            gid_q   <= 1'b0;
            sum_q   <= 16'd0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
            ptr_q   <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            opc_q   <= opc_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            gid_q   <= gid_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
`ifndef ADDER_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign ack      = ack_q;
    assign done     = done_q;
    assign grant_id = gid_q;
    assign sum      = sum_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: one instance with SETTLE_CYCLES=1, one with 4 for reset-abort.
`timescale 1ns/1ps

module tb_adder_arbiter;
    logic        clk = 1'b0;
    logic        n_rst, n_rst_4;
    logic [1:0]  req, req_4;
    logic [15:0] a0, b0, a1, b1, a_4, b_4;
    logic        cin0, cin1, cin_4;
    logic [1:0]  ack, done, ack_4, done_4;
    logic        grant_id, overflow, busy, grant_id_4, overflow_4, busy_4;
    logic [15:0] sum, sum_4;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ack_cyc = 0;
    logic model_ptr = 1'b1;

    typedef struct packed {
        logic        id;
        logic [15:0] sum;
        logic        ovf;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_arbiter #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .n_rst(n_rst), .req(req),
        .a0(a0), .b0(b0), .cin0(cin0), .a1(a1), .b1(b1), .cin1(cin1),
        .ack(ack), .done(done), .grant_id(grant_id), .sum(sum),
        .overflow(overflow), .busy(busy)
    );

    adder_arbiter #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .n_rst(n_rst_4), .req(req_4),
        .a0(a_4), .b0(b_4), .cin0(cin_4), .a1(16'h0000), .b1(16'h0000), .cin1(1'b0),
        .ack(ack_4), .done(done_4), .grant_id(grant_id_4), .sum(sum_4),
        .overflow(overflow_4), .busy(busy_4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic model_win(input logic [1:0] r);
`ifdef ADDER_ARB_FIXED_PRIO_EN
        return r[0] ? 1'b0 : 1'b1;
`else
        if (r == 2'b11) return ~model_ptr;
        return r[0] ? 1'b0 : 1'b1;
`endif
    endfunction

    function automatic exp_t model_add(input logic id, input logic [15:0] a, input logic [15:0] b, input logic c);
        exp_t e;
        logic [16:0] full;
        full  = {1'b0, a} + {1'b0, b} + {16'd0, c};
        e.id  = id;
        e.sum = full[15:0];
        e.ovf = full[16];
        return e;
    endfunction

    // Monitor for the SETTLE_CYCLES=1 instance: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (n_rst && ack != 2'b00) begin
            check_eq("ack_onehot", 32'($countones(ack)), 32'd1);
            ack_cyc = cyc;
        end
        if (n_rst && done != 2'b00) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_done", done, 2'b00);
            end else begin
                e = sb.pop_front();
                $display("done: id=%0d sum=%h ovf=%0d (exp id=%0d sum=%h ovf=%0d)",
                         grant_id, sum, overflow, e.id, e.sum, e.ovf);
                check_eq("done_mask", done, e.id ? 2'b10 : 2'b01);
                check_eq("grant_id", grant_id, e.id);
                check_eq("sum", sum, e.sum);
                check_eq("overflow", overflow, e.ovf);
                check_eq("latency", cyc - ack_cyc, 1);
            end
        end
    end

    task automatic run_ops(input logic [1:0] mask, input logic hold, input int n_ops,
                           input logic [15:0] xa0, input logic [15:0] xb0, input logic xc0,
                           input logic [15:0] xa1, input logic [15:0] xb1, input logic xc1);
        logic [1:0] rm;
        logic       w;
        logic       wins[$];
        int         guard;
        rm = mask;
        for (int k = 0; k < n_ops; k++) begin
            w = model_win(rm);
            wins.push_back(w);
            sb.push_back(w ? model_add(1'b1, xa1, xb1, xc1) : model_add(1'b0, xa0, xb0, xc0));
            model_ptr = w;
            if (!hold) rm[w] = 1'b0;
        end
        @(negedge clk);
        a0 = xa0; b0 = xb0; cin0 = xc0;
        a1 = xa1; b1 = xb1; cin1 = xc1;
        req = mask;
        for (int k = 0; k < n_ops; k++) begin
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (ack == 2'b00 && guard < 50);
            check_eq("ack_id", ack, wins[k] ? 2'b10 : 2'b01);
            if (ack == 2'b00) break;
            if (!hold) req[wins[k]] = 1'b0;
        end
        req = 2'b00;
        guard = 0;
        while ((busy || sb.size() != 0) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("drain_idle", busy, 1'b0);
    endtask

    initial begin
        int guard;
        int k4;
        int dcnt;
        n_rst = 1'b0; n_rst_4 = 1'b0;
        req = 2'b00; req_4 = 2'b00;
        a0 = '0; b0 = '0; cin0 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        a_4 = '0; b_4 = '0; cin_4 = 1'b0;
        #1;
        check_eq("rst_ack", ack, 2'b00);
        check_eq("rst_done", done, 2'b00);
        check_eq("rst_grant_id", grant_id, 1'b0);
        check_eq("rst_sum", sum, 16'h0000);
        check_eq("rst_overflow", overflow, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1; n_rst_4 = 1'b1;

        run_ops(2'b01, 1'b0, 1, 16'hF439, 16'h0024, 1'b1, 16'h0000, 16'h0000, 1'b0);
        run_ops(2'b11, 1'b0, 2, 16'hA6D9, 16'hCC84, 1'b1, 16'h00FF, 16'hFF00, 1'b0);
        run_ops(2'b11, 1'b1, 4, 16'h1234, 16'h4321, 1'b0, 16'h8000, 16'h8001, 1'b1);
        run_ops(2'b10, 1'b0, 1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        run_ops(2'b01, 1'b0, 1, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, 1'b0);

        // Mid-run asynchronous reset must clear the held result at once.
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check_eq("rst2_sum", sum, 16'h0000);
        check_eq("rst2_overflow", overflow, 1'b0);
        check_eq("rst2_grant_id", grant_id, 1'b0);
        check_eq("rst2_busy", busy, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        model_ptr = 1'b1;
        run_ops(2'b11, 1'b0, 2, 16'h0001, 16'h0002, 1'b0, 16'h0003, 16'h0004, 1'b1);

        // SETTLE_CYCLES=4: abort an operation with reset two cycles after its grant.
        @(negedge clk);
        a_4 = 16'h1234; b_4 = 16'h1111; cin_4 = 1'b0; req_4 = 2'b01;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (ack_4 == 2'b00 && guard < 50);
        check_eq("s4_ack1", ack_4, 2'b01);
        req_4 = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #1 n_rst_4 = 1'b0;
        #1;
        check_eq("s4_rst_busy", busy_4, 1'b0);
        check_eq("s4_rst_ack", ack_4, 2'b00);
        @(negedge clk);
        @(negedge clk);
        n_rst_4 = 1'b1;
        dcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_4 != 2'b00) dcnt++;
        end
        check_eq("s4_no_done", dcnt, 0);
        check_eq("s4_sum_held", sum_4, 16'h0000);

        a_4 = 16'h7000; b_4 = 16'h1234; cin_4 = 1'b1; req_4 = 2'b01;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (ack_4 == 2'b00 && guard < 50);
        check_eq("s4_ack2", ack_4, 2'b01);
        k4 = cyc;
        req_4 = 2'b00;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (done_4 == 2'b00 && guard < 50);
        $display("s4 done: sum=%h ovf=%0d latency=%0d", sum_4, overflow_4, cyc - k4);
        check_eq("s4_done", done_4, 2'b01);
        check_eq("s4_latency", cyc - k4, 4);
        check_eq("s4_sum", sum_4, 16'h8235);
        check_eq("s4_overflow", overflow_4, 1'b0);
        check_eq("s4_grant_id", grant_id_4, 1'b0);

        check_eq("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Sequential controller that shares one `adder_16bit` instance between two requesters. It accepts operand sets over a req/ack handshake and arbitrates round-robin when both requesters are active. It holds the adder inputs stable for a programmable settle time, then returns a registered sum and overflow tagged with the owning requester. It sits between the lab's operand sources and the combinational adder datapath.

## Interface
- `SETTLE_CYCLES`, default 1: cycles the adder inputs are held before capture; legal range 1..15.

- `clk` in 1: system clock, rising edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `req` in 2: per-requester request level; bit i belongs to requester i.
- `a0`, `b0` in 16 each: requester 0 operands.
- `cin0` in 1: requester 0 carry-in.
- `a1`, `b1` in 16 each: requester 1 operands.
- `cin1` in 1: requester 1 carry-in.
- `ack` out 2: one-cycle pulse; operands of requester i captured.
- `done` out 2: one-cycle pulse; `sum`/`overflow` valid for requester i.
- `grant_id` out 1: requester owning the current or last operation.
- `sum` out 16: registered sum, held until the next `done`.
- `overflow` out 1: registered carry out of bit 15.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE, `req` == 0: stay in IDLE.
- IDLE, `req` != 0: select winner w.
  - Latch `a_w`, `b_w`, `cin_w` into the operand registers.
  - `ack[w]`<=1, `grant_id`<=w, `busy`<=1.
  - Load the counter with SETTLE_CYCLES-1, go to CALC.
  - Update the last-grant pointer to w.
- Arbitration is round-robin. If only one bit of `req` is set, that requester wins. If both are set, the requester not granted last wins. The pointer resets to 1, so requester 0 wins the first tie.
- CALC:
  - `ack`<=0 on the first CALC edge.
  - Counter != 0: decrement the counter.
  - Counter == 0: `sum`<=adder sum, `overflow`<=adder overflow, `done[grant_id]`<=1, go to DONE.
- DONE: `done`<=0, `busy`<=0, go to IDLE.
- The adder inputs come only from the operand registers and stay constant through CALC.
- Arithmetic: {`overflow`,`sum`} = a + b + cin, computed at 17 bits with no truncation other than bit 16 going to `overflow`.
- Requester rules:
  - Hold `req` and operands stable until `ack[i]` is seen.
  - Drop `req` in the cycle `ack[i]` is seen, or that requester is served again.
  - `req` still high when the block returns to IDLE is a new request.
- Changes on `req` or on operand inputs during CALC/DONE are ignored.

## Timing
- Reset values: `ack`=0, `done`=0, `grant_id`=0, `sum`=0, `overflow`=0, `busy`=0, state=IDLE, counter=0, pointer=1.
- E0 is the grant edge.
  - `ack` is high during cycle E0..E1.
  - `done` is high during E0+SETTLE_CYCLES .. +1.
  - The block is in IDLE again after E0+SETTLE_CYCLES+1.
  - The earliest next grant is at E0+SETTLE_CYCLES+2.
- One operation completes per SETTLE_CYCLES+2 cycles.
- `sum`/`overflow` change only on the `done` edge.
- Reset asserted mid-operation: the operation is discarded and no `done` is issued. All outputs go to their reset values immediately (asynchronous). The first rising edge after release evaluates IDLE.
- Simultaneous `req` rise of both requesters in IDLE is resolved by the pointer. Exactly one `ack` bit is ever set at a time.

## Configuration
- `ADDER_ARB_FIXED_PRIO_EN` defined: fixed priority; requester 0 always wins when both request, and the pointer is not implemented.
- `ADDER_ARB_FIXED_PRIO_EN` undefined: round-robin as specified above.

## Test plan
- Reset check: assert `n_rst`=0 mid-run, then release. All outputs must be 0 and `busy`=0.
- Single request, SETTLE_CYCLES=1: requester 0 with a0=F439, b0=0024, cin0=1.
  - `ack`=01 after E0 and `done`=01 after E1.
  - `sum`=F45E, `overflow`=0, `grant_id`=0.
- Simultaneous first request:
  - Requester 0: A6D9+CC84+1. Requester 1: 00FF+FF00+0.
  - Requester 0 is served first: `sum`=735E, `overflow`=1.
  - Then requester 1: `sum`=FFFF, `overflow`=0, `grant_id`=1.
- Fairness: both `req` held high for 4 operations.
  - Without the macro, grant order is 0,1,0,1.
  - With `ADDER_ARB_FIXED_PRIO_EN`, grant order is 0,0,0,0.
- Carry chain: FFFF+FFFF+1 -> `sum`=FFFF, `overflow`=1. Also 0000+0000+0 -> `sum`=0000, `overflow`=0.
- Reset mid-CALC with SETTLE_CYCLES=4: pulse `n_rst` low 2 cycles after grant.
  - No `done` pulse; `sum` stays 0.
  - A new request is then served with normal latency: `done` SETTLE_CYCLES edges after its grant.
